// File: rtl/asym_sync_fifo.sv
// asym_sync_fifo
//   Single-clock FIFO whose write and read words may differ in width by a
//   power-of-two ratio in either direction. Storage is organised in units of
//   the narrower width; a wide access touches WR_WIDTH/min (or RD_WIDTH/min)
//   consecutive units, little-endian (lowest lane at the lowest address).
//
// Ports
//   CLK          sole clock, rising edge
//   RST          asynchronous active-high reset
//   CLEAR        synchronous flush, same effect as RST, wins over WRITE/READ
//   WRITE        write strobe, accepted when !FULL
//   DATA_IN      write word (WR_WIDTH bits)
//   READ         read strobe, accepted when !EMPTY
//   DATA_OUT     registered read word (RD_WIDTH bits), holds when no read
//   FULL         free units < WR_WIDTH/min
//   EMPTY        stored units < RD_WIDTH/min
//   ALMOST_FULL  FILL >= ALMOST_FULL_THR
//   FILL         stored units
//   OVERFLOW     sticky, write attempted while FULL
//   UNDERFLOW    sticky, read attempted while EMPTY
//
// Parameter constraints (not checked in hardware): max/min of the widths is a
// power of two in 1..64, DEPTH is a power of two and at least 2*max/min.

module asym_sync_fifo #(
  parameter int WR_WIDTH        = 8,
  parameter int RD_WIDTH        = 1,
  parameter int DEPTH           = 16384,
  parameter int ALMOST_FULL_THR = DEPTH - DEPTH / 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CLEAR,
  input  logic                       WRITE,
  input  logic [WR_WIDTH-1:0]        DATA_IN,
  input  logic                       READ,
  output logic [RD_WIDTH-1:0]        DATA_OUT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ALMOST_FULL,
  output logic [$clog2(DEPTH):0]     FILL,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int MIN_W    = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
  localparam int WR_UNITS = WR_WIDTH / MIN_W;
  localparam int RD_UNITS = RD_WIDTH / MIN_W;
  localparam int AW       = $clog2(DEPTH);
  localparam int FW       = AW + 1;

  localparam logic [AW-1:0] WR_STEP  = AW'(WR_UNITS);
  localparam logic [AW-1:0] RD_STEP  = AW'(RD_UNITS);
  localparam logic [FW-1:0] WR_INC   = FW'(WR_UNITS);
  localparam logic [FW-1:0] RD_INC   = FW'(RD_UNITS);
  localparam logic [FW-1:0] FULL_LIM = FW'(DEPTH - WR_UNITS);
  localparam logic [FW-1:0] AF_THR   = FW'(ALMOST_FULL_THR);

  logic [MIN_W-1:0]    mem_q [DEPTH];

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [RD_WIDTH-1:0] dout_q, dout_d;

  logic                full_s;
  logic                empty_s;
  logic                af_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic [RD_WIDTH-1:0] rd_word_s;

  // Flags are decoded from the registered fill, so they react to RST at once.
  always_comb begin
    full_s  = (fill_q > FULL_LIM);
    empty_s = (fill_q < RD_INC);
    af_s    = (fill_q >= AF_THR);
    // CLEAR blocks both ports so a flush cannot race with a transfer.
    wr_en_s = WRITE & ~full_s & ~CLEAR;
    rd_en_s = READ & ~empty_s & ~CLEAR;
  end

  // Gather the read word; lane k comes from unit rd_ptr + k.
  always_comb begin
    rd_word_s = {RD_WIDTH{1'b0}};
    for (int k = 0; k < RD_UNITS; k++) begin
      rd_word_s[k*MIN_W +: MIN_W] = mem_q[rd_ptr_q + AW'(k)];
    end
  end

  // Next-state for pointers, fill, sticky flags and the output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    dout_d   = dout_q;
    if (CLEAR) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      fill_d   = {FW{1'b0}};
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      dout_d   = {RD_WIDTH{1'b0}};
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + WR_STEP;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + RD_STEP;
        dout_d   = rd_word_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
      end
      fill_d = fill_q + (wr_en_s ? WR_INC : {FW{1'b0}})
                      - (rd_en_s ? RD_INC : {FW{1'b0}});
      ovf_d  = ovf_q | (WRITE & full_s);
      udf_d  = udf_q | (READ & empty_s);
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      fill_q   <= {FW{1'b0}};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= {RD_WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array; deliberately not reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      for (int k = 0; k < WR_UNITS; k++) begin
        mem_q[wr_ptr_q + AW'(k)] <= DATA_IN[k*MIN_W +: MIN_W];
      end
    end
  end

  assign DATA_OUT    = dout_q;
  assign FULL        = full_s;
  assign EMPTY       = empty_s;
  assign ALMOST_FULL = af_s;
  assign FILL        = fill_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = udf_q;

endmodule
